// File: rtl/regfile_param.sv
// Parametrised register file: two write ports (M beats E on collision), two registered
// read ports with write-through forwarding, and a per-register pending scoreboard.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            dstE,
    input  logic [DATA_W-1:0]            valE,
    input  logic [ADDR_W-1:0]            dstM,
    input  logic [DATA_W-1:0]            valM,
    input  logic [ADDR_W-1:0]            rA,
    input  logic [ADDR_W-1:0]            rB,
    input  logic [ADDR_W-1:0]            pend_set,
    output logic [DATA_W-1:0]            valA,
    output logic [DATA_W-1:0]            valB,
    output logic                         hazard,
    output logic [NUM_REGS-1:0]          pending,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat
);

    localparam logic [ADDR_W-1:0] NREG = ADDR_W'(NUM_REGS);

    logic [DATA_W-1:0] r [NUM_REGS];
    logic [ADDR_W-1:0] raddr [2];
    logic [DATA_W-1:0] rdata [2];

    assign raddr[0] = rA;
    assign raddr[1] = rB;

    // An invalid read address must not match an invalid write address (e.g. RNONE == RNONE).
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (raddr[p] == ADDR_W'(i)) rdata[p] = r[i];
            end
            if (raddr[p] < NREG) begin
                if (raddr[p] == dstM)      rdata[p] = valM;
                else if (raddr[p] == dstE) rdata[p] = valE;
            end
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ((rA == ADDR_W'(i) || rB == ADDR_W'(i)) && pending[i]) hazard = 1'b1;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = r[i];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) r[i] <= '0;
            pending <= '0;
            valA    <= '0;
            valB    <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (dstM == ADDR_W'(i))      r[i] <= valM;
                else if (dstE == ADDR_W'(i)) r[i] <= valE;
                // A reissue in the same cycle as the old writeback keeps the bit set.
                if (pend_set == ADDR_W'(i))                          pending[i] <= 1'b1;
                else if (dstE == ADDR_W'(i) || dstM == ADDR_W'(i))   pending[i] <= 1'b0;
            end
            valA <= rdata[0];
            valB <= rdata[1];
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default 8x32 instance plus a 15x64 instance.
module tb_regfile_param;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  dstE, dstM, rA, rB, pend_set;
    logic [31:0] valE, valM, valA, valB;
    logic        hazard;
    logic [7:0]  pending;
    logic [255:0] regs_flat;

    logic [3:0]  dstE2, dstM2, rA2, rB2, pend_set2;
    logic [63:0] valE2, valM2, valA2, valB2;
    logic        hazard2;
    logic [14:0] pending2;
    logic [959:0] regs_flat2;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] m [8];

    regfile_param dut (
        .clock(clock), .reset(reset), .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .rA(rA), .rB(rB), .pend_set(pend_set), .valA(valA), .valB(valB),
        .hazard(hazard), .pending(pending), .regs_flat(regs_flat)
    );

    regfile_param #(.DATA_W(64), .NUM_REGS(15), .ADDR_W(4)) dut2 (
        .clock(clock), .reset(reset), .dstE(dstE2), .valE(valE2), .dstM(dstM2), .valM(valM2),
        .rA(rA2), .rB(rB2), .pend_set(pend_set2), .valA(valA2), .valB(valB2),
        .hazard(hazard2), .pending(pending2), .regs_flat(regs_flat2)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        dstE = 4'hF; dstM = 4'hF; pend_set = 4'hF; rA = 4'hF; rB = 4'hF;
        valE = 32'hDEAD_0001; valM = 32'hDEAD_0002;
    endtask

    function automatic logic [255:0] packm();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = m[i];
        return v;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        idle();
        dstE2 = 4'hF; dstM2 = 4'hF; rA2 = 4'hF; rB2 = 4'hF; pend_set2 = 4'hF;
        valE2 = '0; valM2 = '0;
        for (int i = 0; i < 8; i++) m[i] = 32'h0;

        // reset held while clocking with a write presented
        dstE = 4'h2; valE = 32'h1234; rA = 4'h2; rB = 4'h2; pend_set = 4'h2;
        tick(); tick();
        check("reset_flat",    regs_flat, 256'h0);
        check("reset_valA",    {224'h0, valA}, 256'h0);
        check("reset_valB",    {224'h0, valB}, 256'h0);
        check("reset_pending", {248'h0, pending}, 256'h0);
        check("reset_hazard",  {255'h0, hazard}, 256'h0);

        reset = 1'b1;
        pend_set = 4'hF; rA = 4'hF; rB = 4'hF;
        tick();
        m[2] = 32'h1234;
        check("release_write_R2", regs_flat, packm());

        idle();
        dstE = 4'h0; valE = 32'hABCDEF98; dstM = 4'h1; valM = 32'h7654321A;
        tick();
        m[0] = 32'hABCDEF98; m[1] = 32'h7654321A;
        check("dual_write", regs_flat, packm());

        idle();
        dstE = 4'h5; valE = 32'h1; dstM = 4'h5; valM = 32'h2;
        tick();
        m[5] = 32'h2;
        check("collision_M_wins", regs_flat, packm());

        idle();
        valE = 32'hCAFE_0001; valM = 32'hCAFE_0002;
        tick();
        check("rnone_no_write", regs_flat, packm());
        check("rnone_read_zero", {224'h0, valA}, 256'h0);

        idle();
        rA = 4'h1; rB = 4'h5;
        tick();
        check("plain_read_A", {224'h0, valA}, {224'h0, 32'h7654321A});
        check("plain_read_B", {224'h0, valB}, {224'h0, 32'h2});

        idle();
        dstE = 4'h3; valE = 32'h11;
        tick();
        m[3] = 32'h11;
        idle();
        rA = 4'h3; dstE = 4'h3; valE = 32'h22;
        tick();
        m[3] = 32'h22;
        check("fwd_E_valA", {224'h0, valA}, {224'h0, 32'h22});
        idle();
        rB = 4'h3; dstE = 4'h3; valE = 32'h33; dstM = 4'h3; valM = 32'h44;
        tick();
        m[3] = 32'h44;
        check("fwd_M_valB", {224'h0, valB}, {224'h0, 32'h44});
        check("fwd_array", regs_flat, packm());

        idle();
        pend_set = 4'h6;
        tick();
        idle();
        check("pend_set6", {248'h0, pending}, {248'h0, 8'h40});
        rA = 4'h6; #1;
        check("hazard_rA6", {255'h0, hazard}, {255'h0, 1'b1});
        rA = 4'h5; #1;
        check("hazard_rA5", {255'h0, hazard}, 256'h0);
        rB = 4'h6; #1;
        check("hazard_rB6", {255'h0, hazard}, {255'h0, 1'b1});
        rA = 4'hF; rB = 4'hF;
        dstM = 4'h6; valM = 32'h66;
        tick();
        m[6] = 32'h66;
        check("pend_clear_M", {248'h0, pending}, 256'h0);
        idle();
        pend_set = 4'h6; dstE = 4'h6; valE = 32'h77;
        tick();
        m[6] = 32'h77;
        check("pend_set_beats_clear", {248'h0, pending}, {248'h0, 8'h40});
        check("pend_array", regs_flat, packm());

        // async reset mid-operation
        idle();
        dstE = 4'h0; valE = 32'h5555_5555; rA = 4'h1; pend_set = 4'h7;
        #1 reset = 1'b0;
        #1;
        check("async_flat",    regs_flat, 256'h0);
        check("async_pending", {248'h0, pending}, 256'h0);
        check("async_valA",    {224'h0, valA}, 256'h0);
        idle();
        tick();
        reset = 1'b1;
        tick();

        // 15x64 instance
        dstE2 = 4'hE; valE2 = 64'hFFFF_0000_FFFF_0000; rA2 = 4'hE;
        tick();
        check("p_R14_write", {192'h0, regs_flat2[14*64 +: 64]}, {192'h0, 64'hFFFF_0000_FFFF_0000});
        check("p_R14_fwd", {192'h0, valA2}, {192'h0, 64'hFFFF_0000_FFFF_0000});
        dstE2 = 4'hF; valE2 = 64'h1234_5678_9ABC_DEF0; pend_set2 = 4'hE;
        tick();
        check("p_R14_read", {192'h0, valA2}, {192'h0, 64'hFFFF_0000_FFFF_0000});
        check("p_pending14", {241'h0, pending2}, {241'h0, 15'h4000});
        for (int i = 0; i < 14; i++)
            check($sformatf("p_R%0d_untouched", i), {192'h0, regs_flat2[i*64 +: 64]}, 256'h0);
        check("p_R14_kept", {192'h0, regs_flat2[14*64 +: 64]}, {192'h0, 64'hFFFF_0000_FFFF_0000});
        rA2 = 4'hF; pend_set2 = 4'hF;
        tick();
        check("p_rnone_read", {192'h0, valA2}, 256'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
